byte_packer: RTL and testbench

BYTE_PACKER -- requirements
Module: byte_packer

---
 rtl/rsa_pkg.sv | 25 ++
 rtl/byte_packer.sv | 103 ++++++++++
 tb/tb_byte_packer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_pkg
//  Description : Shared types and constants for the RSA operand front end.
//  Revision    : 1.0
// ============================================================================
package rsa_pkg;

   localparam int c_WORD_BYTES_DEFAULT = 4;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      CAPTURE = 2'd1,
      HOLD    = 2'd2
   } state_t;

   // Byte lane that receives the next captured byte.
   function automatic logic [3:0] lane_of(input logic [3:0] count,
                                          input logic [3:0] nbytes,
                                          input logic       msb_first);
      return msb_first ? (nbytes - 4'd1 - count) : count;
   endfunction

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Packs bytes from an 8-bit FIFO into WORD_BYTES-wide words.
//  Revision    : 1.0
// ============================================================================
module byte_packer
   import rsa_pkg::*;
#(
   parameter int WORD_BYTES = c_WORD_BYTES_DEFAULT,
   parameter bit MSB_FIRST  = 1'b1
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              buf_out,
   input  logic                    buf_empty,
   output logic                    rd_en,
   input  logic                    flush,
   output logic [8*WORD_BYTES-1:0] word_out,
   output logic                    word_valid,
   input  logic                    word_ready,
   output logic [3:0]              word_bytes
);

   localparam logic [3:0] c_FULL = 4'(WORD_BYTES);

   state_t                  r_state;
   state_t                  w_state_next;
   logic [3:0]              r_count;
   logic [8*WORD_BYTES-1:0] r_word;
   logic                    r_valid;
   logic [3:0]              r_bytes;
   logic                    w_flush_go;
   logic                    w_last;
   logic                    w_accept;
   logic [3:0]              w_lane;

   assign w_last   = (r_count + 4'd1 == c_FULL);
   assign w_accept = r_valid && word_ready;
   assign w_lane   = lane_of(r_count, c_FULL, MSB_FIRST);

   always_comb begin
      w_state_next = r_state;
      rd_en        = 1'b0;
      w_flush_go   = 1'b0;
      case (r_state)
         FETCH: begin
            // A pending flush with data wins over a pop.
            if (flush && (r_count != 4'd0)) begin
               w_flush_go   = 1'b1;
               w_state_next = HOLD;
            end else if (!buf_empty && !rst) begin
               rd_en        = 1'b1;
               w_state_next = CAPTURE;
            end
         end
         CAPTURE: w_state_next = w_last ? HOLD : FETCH;
         HOLD:    if (w_accept) w_state_next = FETCH;
         default: w_state_next = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= FETCH;
      else     r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= 4'd0;
         r_word  <= '0;
         r_valid <= 1'b0;
         r_bytes <= 4'd0;
      end else if (r_state == CAPTURE) begin
         for (int i = 0; i < WORD_BYTES; i++) begin
            if (w_lane == 4'(i)) r_word[8*i +: 8] <= buf_out;
         end
         r_count <= r_count + 4'd1;
         if (w_last) begin
            r_valid <= 1'b1;
            r_bytes <= c_FULL;
         end
      end else if (r_state == FETCH) begin
         if (w_flush_go) begin
            r_valid <= 1'b1;
            r_bytes <= r_count;
         end
      end else if (r_state == HOLD) begin
         if (w_accept) begin
            r_count <= 4'd0;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_bytes <= 4'd0;
         end
      end
   end

   assign word_out   = r_word;
   assign word_valid = r_valid;
   assign word_bytes = r_bytes;

endmodule
`default_nettype wire

// File: tb/tb_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_packer
//  Description : Self-checking bench for byte_packer in both lane orders.
//  Revision    : 1.0
// ============================================================================
module tb_byte_packer;

   localparam int W = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  buf_out;
   logic        buf_empty;
   logic        flush;
   logic        word_ready;
   logic        rd_en_m, rd_en_l;
   logic [31:0] word_out_m, word_out_l;
   logic        word_valid_m, word_valid_l;
   logic [3:0]  word_bytes_m, word_bytes_l;

   always #5 clk = ~clk;

   byte_packer #(.WORD_BYTES(W), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .buf_out(buf_out), .buf_empty(buf_empty),
      .rd_en(rd_en_m), .flush(flush), .word_out(word_out_m),
      .word_valid(word_valid_m), .word_ready(word_ready), .word_bytes(word_bytes_m));

   byte_packer #(.WORD_BYTES(W), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst(rst), .buf_out(buf_out), .buf_empty(buf_empty),
      .rd_en(rd_en_l), .flush(flush), .word_out(word_out_l),
      .word_valid(word_valid_l), .word_ready(word_ready), .word_bytes(word_bytes_l));

   int checks = 0;
   int errors = 0;

   logic [7:0]  fifo_q[$];
   logic [7:0]  partial[$];
   logic [31:0] exp_m[$];
   logic [31:0] exp_l[$];
   logic [3:0]  exp_n[$];
   logic        hide = 1'b0;
   int          pops = 0;
   int          accepted = 0;
   int          cyc = 0;
   int          first_pop_cyc = -1;
   int          hs_cyc = -1;
   logic [31:0] last_m, last_l;
   logic [3:0]  last_n;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference packing: byte i of a word goes to lane W-1-i (MSB first) or lane i.
   task automatic model_emit();
      logic [31:0] m = '0;
      logic [31:0] l = '0;
      for (int i = 0; i < partial.size(); i++) begin
         m = m | (32'(partial[i]) << (8 * (W - 1 - i)));
         l = l | (32'(partial[i]) << (8 * i));
      end
      exp_m.push_back(m);
      exp_l.push_back(l);
      exp_n.push_back(4'(partial.size()));
      partial.delete();
   endtask

   task automatic model_push(input logic [7:0] b);
      partial.push_back(b);
      if (partial.size() == W) model_emit();
   endtask

   task automatic model_flush();
      if (partial.size() > 0) model_emit();
   endtask

   task automatic model_reset();
      partial.delete();
      exp_m.delete();
      exp_l.delete();
      exp_n.delete();
   endtask

   // One clock: inputs already set by the caller; sampled before the edge.
   task automatic cycle();
      logic pop;
      logic hs;
      buf_empty = (fifo_q.size() == 0) || hide;
      #1;
      pop = rd_en_m;
      hs  = word_valid_m && word_ready;
      chk("rd_en_while_empty", rd_en_m && buf_empty, 1'b0);
      chk("rd_en_lanes_agree", rd_en_m, rd_en_l);
      if (rst) chk("rd_en_in_reset", rd_en_m, 1'b0);
      if (hs) begin
         last_m = word_out_m;
         last_l = word_out_l;
         last_n = word_bytes_m;
         hs_cyc = cyc;
         accepted++;
         if (exp_m.size() == 0) begin
            chk("unexpected_word", 1'b1, 1'b0);
         end else begin
            chk("word_msb", word_out_m, exp_m.pop_front());
            chk("word_lsb", word_out_l, exp_l.pop_front());
            chk("word_bytes", word_bytes_m, exp_n.pop_front());
         end
      end
      @(posedge clk);
      #1;
      if (pop) begin
         if (first_pop_cyc < 0) first_pop_cyc = cyc;
         if (fifo_q.size() > 0) begin
            buf_out = fifo_q.pop_front();
            model_push(buf_out);
         end
         pops++;
      end
      cyc++;
   endtask

   task automatic wait_hs(input string tag, input int budget);
      int a0 = accepted;
      int n  = 0;
      while (accepted == a0 && n < budget) begin
         cycle();
         n++;
      end
      if (accepted == a0) chk({tag, "_timeout"}, 1'b1, 1'b0);
   endtask

   initial begin
      int p0;
      int n;
      logic [31:0] held;

      rst = 1'b1; buf_out = 8'h00; buf_empty = 1'b1; flush = 1'b0; word_ready = 1'b0;
      repeat (3) cycle();
      chk("rst_valid", word_valid_m, 1'b0);
      chk("rst_word", word_out_m, 32'h0);
      chk("rst_bytes", word_bytes_m, 4'h0);
      chk("rst_word_l", word_out_l, 32'h0);
      rst = 1'b0;

      // Full word, MSB and LSB lane orders, ready held high.
      word_ready = 1'b1;
      fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      p0 = pops; first_pop_cyc = -1;
      wait_hs("full", 40);
      chk("full_pops", 32'(pops - p0), 32'd4);
      chk("full_msb", last_m, 32'h11223344);
      chk("full_lsb", last_l, 32'h44332211);
      chk("full_n", last_n, 4'd4);
      chk("full_latency", (hs_cyc - first_pop_cyc) >= 2 * W, 1'b1);
      chk("single_valid", word_valid_m, 1'b0);
      chk("cleared_word", word_out_m, 32'h0);

      // Partial word then flush.
      fifo_q = '{8'hAA, 8'hBB};
      repeat (8) cycle();
      chk("partial_no_valid", word_valid_m, 1'b0);
      flush = 1'b1;
      model_flush();
      wait_hs("flush", 10);
      flush = 1'b0;
      chk("flush_msb", last_m, 32'hAABB0000);
      chk("flush_lsb", last_l, 32'h0000BBAA);
      chk("flush_n", last_n, 4'd2);
      flush = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("flush_empty_ignored", word_valid_m, 1'b0);
      end
      flush = 1'b0;

      // Backpressure: word held while ready is low, more bytes waiting.
      word_ready = 1'b0;
      fifo_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
      n = 0;
      while (!word_valid_m && n < 30) begin cycle(); n++; end
      chk("bp_reach_valid", word_valid_m, 1'b1);
      held = word_out_m;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("bp_stable", word_out_m, held);
         chk("bp_valid", word_valid_m, 1'b1);
         chk("bp_no_rd", rd_en_m, 1'b0);
      end
      word_ready = 1'b1;
      p0 = accepted;
      cycle();
      chk("bp_accept_now", 32'(accepted - p0), 32'd1);
      chk("bp_word", last_m, 32'hA1A2A3A4);
      wait_hs("bp_second", 30);
      chk("bp_second_word", last_m, 32'hB1B2B3B4);

      // Reset with three bytes captured.
      fifo_q = '{8'hC1, 8'hC2, 8'hC3};
      repeat (7) cycle();
      rst = 1'b1;
      model_reset();
      cycle();
      rst = 1'b0;
      chk("mid_rst_valid", word_valid_m, 1'b0);
      chk("mid_rst_word", word_out_m, 32'h0);
      fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04};
      wait_hs("post_rst", 40);
      chk("post_rst_word", last_m, 32'h01020304);

      // Random FIFO availability and backpressure over 64 bytes.
      p0 = accepted;
      for (int i = 0; i < 64; i++) fifo_q.push_back(8'($urandom));
      n = 0;
      while ((fifo_q.size() > 0 || exp_m.size() > 0) && n < 3000) begin
         hide       = ($urandom_range(0, 2) == 0);
         word_ready = 1'($urandom);
         cycle();
         n++;
      end
      hide = 1'b0;
      chk("rand_done", (fifo_q.size() == 0) && (exp_m.size() == 0), 1'b1);
      chk("rand_words", 32'(accepted - p0), 32'd16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
